// File: rtl/music_pkg.sv
// Shared widths, flag positions and scheduler state encoding for the music player blocks.
package music_pkg;
   localparam int NOTE_W     = 6;
   localparam int DUR_W      = 6;
   localparam int META_W     = 3;
   localparam int META_CHORD = 0;

   localparam logic [NOTE_W-1:0] NOTE_REST = '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_LOAD,
      S_HOLD,
      S_DRAIN
   } state_t;
endpackage

// File: rtl/voice_slot.sv
// One note-player timer: counts remaining beats of the note it was loaded with.
module voice_slot
   import music_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DUR_W-1:0] dur,
   input  logic             beat_en,
   output logic [DUR_W-1:0] count,
   output logic             active
);

   // A load wins over a coincident beat so the new note gets its full length.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        count <= '0;
      else if (load)                     count <= dur;
      else if (beat_en && count != '0)   count <= count - 1'b1;
   end

   assign active = (count != '0);

endmodule

// File: rtl/voice_scheduler.sv
// Fetches notes from the song reader, assigns them to voice slots and paces fetches on beats.
module voice_scheduler
   import music_pkg::*;
#(
   parameter int NUM_VOICES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  play,
   input  logic                  beat,
   input  logic                  new_note,
   input  logic [NOTE_W-1:0]     note,
   input  logic [DUR_W-1:0]      duration,
   input  logic [META_W-1:0]     metadata,
   input  logic                  song_done,
   output logic                  note_done,
   output logic [NUM_VOICES-1:0] voice_load,
   output logic [NOTE_W-1:0]     voice_note,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic                  steal,
   output logic                  finished
);

   state_t state, state_nx;

   logic [NOTE_W-1:0]                  note_q;
   logic [DUR_W-1:0]                   dur_q;
   logic                               chord_q;
   logic [DUR_W-1:0]                   adv_cnt;
   logic                               beat_en;
   logic                               take_note;
   logic                               do_load;
   logic                               all_busy;
   logic [NUM_VOICES-1:0]              act;
   logic [NUM_VOICES-1:0]              free_oh;
   logic [NUM_VOICES-1:0]              min_oh;
   logic [NUM_VOICES-1:0][DUR_W-1:0]   cnt;
   logic [DUR_W-1:0]                   best_cnt;
   logic                               found;
   logic                               unused_meta;

   // Only the chord flag matters to scheduling; other metadata bits belong to other blocks.
   assign unused_meta = ^metadata;

   assign beat_en   = beat & play;
   assign take_note = (state == S_WAIT) && new_note && !(play && song_done);

   // ---------------- voice allocation ----------------
   always_comb begin
      free_oh  = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!act[i] && !found) begin
            free_oh[i] = 1'b1;
            found      = 1'b1;
         end
      end
      // Strict '<' while scanning upward keeps the lowest index on ties.
      min_oh    = '0;
      min_oh[0] = 1'b1;
      best_cnt  = cnt[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (cnt[i] < best_cnt) begin
            best_cnt  = cnt[i];
            min_oh    = '0;
            min_oh[i] = 1'b1;
         end
      end
   end

   assign all_busy   = &act;
   assign do_load    = (state == S_LOAD) && play && (note_q != NOTE_REST) && (dur_q != '0);
   assign voice_load = do_load ? (all_busy ? min_oh : free_oh) : '0;
   assign steal      = do_load && all_busy;
   assign voice_note = note_q;

   // ---------------- voice slots ----------------
   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
      voice_slot u_slot (
         .clk     (clk),
         .reset   (reset),
         .load    (voice_load[g]),
         .dur     (dur_q),
         .beat_en (beat_en),
         .count   (cnt[g]),
         .active  (act[g])
      );
   end

   assign voice_active = act;

   // ---------------- sequencing FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      note_done = 1'b0;
      finished  = 1'b0;
      case (state)
         S_IDLE:  if (play) state_nx = S_REQ;
         S_REQ:   if (play) begin
                     note_done = 1'b1;
                     state_nx  = S_WAIT;
                  end
         S_WAIT:  if (play && song_done) state_nx = S_DRAIN;
                  else if (new_note)     state_nx = S_LOAD;
         // A note latched while paused waits here until play resumes.
         S_LOAD:  if (play) state_nx = (chord_q || dur_q == '0) ? S_REQ : S_HOLD;
         S_HOLD:  if (beat_en && adv_cnt == DUR_W'(1)) state_nx = S_REQ;
         S_DRAIN: if (play && act == '0) begin
                     finished = 1'b1;
                     state_nx = S_IDLE;
                  end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         note_q  <= '0;
         dur_q   <= '0;
         chord_q <= 1'b0;
      end else if (take_note) begin
         note_q  <= note;
         dur_q   <= duration;
         chord_q <= metadata[META_CHORD];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         adv_cnt <= '0;
      else if (state == S_LOAD && play)
         adv_cnt <= dur_q;
      else if (state == S_HOLD && beat_en && adv_cnt != '0)
         adv_cnt <= adv_cnt - 1'b1;
   end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: scoreboard of expected voice loads plus inline checks.
module tb_voice_scheduler;
   localparam int NV = 3;

   logic          clk;
   logic          reset;
   logic          play;
   logic          beat;
   logic          new_note;
   logic [5:0]    note;
   logic [5:0]    duration;
   logic [2:0]    metadata;
   logic          song_done;
   logic          note_done;
   logic [NV-1:0] voice_load;
   logic [5:0]    voice_note;
   logic [NV-1:0] voice_active;
   logic          steal;
   logic          finished;

   typedef struct {
      logic [NV-1:0] load;
      logic [5:0]    note;
      logic          steal;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   voice_scheduler #(.NUM_VOICES(NV)) dut (
      .clk          (clk),
      .reset        (reset),
      .play         (play),
      .beat         (beat),
      .new_note     (new_note),
      .note         (note),
      .duration     (duration),
      .metadata     (metadata),
      .song_done    (song_done),
      .note_done    (note_done),
      .voice_load   (voice_load),
      .voice_note   (voice_note),
      .voice_active (voice_active),
      .steal        (steal),
      .finished     (finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
      end
   endtask

   // Every voice_load pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && voice_load !== '0) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL unexpected_load: observed load=%b note=%0d, required no load", voice_load, voice_note);
         end else begin
            e = sb.pop_front();
            assert ({voice_load, voice_note, steal} === {e.load, e.note, e.steal}) else begin
               n_fail++;
               $error("FAIL sb_load: observed load=%b note=%0d steal=%b, required load=%b note=%0d steal=%b",
                      voice_load, voice_note, steal, e.load, e.note, e.steal);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_beat();
      beat = 1'b1;
      step(1);
      beat = 1'b0;
   endtask

   task automatic wait_nd();
      int k = 0;
      while (note_done !== 1'b1 && k < 50) begin
         step(1);
         k++;
      end
      chk("wait_note_done", {31'd0, note_done}, 32'd1);
   endtask

   // Answers one note request; returns in the cycle after LOAD.
   task automatic give_note(input logic [5:0] n, input logic [5:0] d, input logic [2:0] m,
                            input logic [NV-1:0] exp_ld, input logic exp_st);
      exp_t e;
      wait_nd();
      step(1);
      new_note = 1'b1;
      note     = n;
      duration = d;
      metadata = m;
      if (exp_ld != '0) begin
         e.load  = exp_ld;
         e.note  = n;
         e.steal = exp_st;
         sb.push_back(e);
      end
      step(1);
      new_note = 1'b0;
      step(1);
   endtask

   initial begin
      reset = 1'b0; play = 1'b0; beat = 1'b0; new_note = 1'b0;
      note = '0; duration = '0; metadata = '0; song_done = 1'b0;
      step(2);
      chk("rst_active",   {29'd0, voice_active}, 32'd0);
      chk("rst_note_done", {31'd0, note_done},   32'd0);
      chk("rst_load",     {29'd0, voice_load},   32'd0);
      chk("rst_finished", {31'd0, finished},     32'd0);
      reset = 1'b1;
      play  = 1'b1;
      chk("idle_no_req", {31'd0, note_done}, 32'd0);
      step(1);
      chk("first_req", {31'd0, note_done}, 32'd1);

      // single note, 3 beats
      give_note(6'd12, 6'd3, 3'b000, 3'b001, 1'b0);
      chk("single_gate", {29'd0, voice_active}, 32'b001);
      do_beat(); do_beat();
      chk("single_hold", {31'd0, note_done}, 32'd0);
      chk("single_gate2", {29'd0, voice_active}, 32'b001);
      do_beat();
      chk("single_req", {31'd0, note_done}, 32'd1);
      chk("single_drop", {29'd0, voice_active}, 32'd0);

      // three-note chord
      give_note(6'd20, 6'd4, 3'b001, 3'b001, 1'b0);
      chk("chord_rereq", {31'd0, note_done}, 32'd1);
      give_note(6'd22, 6'd4, 3'b001, 3'b010, 1'b0);
      give_note(6'd24, 6'd4, 3'b000, 3'b100, 1'b0);
      do_beat(); do_beat(); do_beat();
      chk("chord_gates", {29'd0, voice_active}, 32'b111);
      do_beat();
      chk("chord_drop", {29'd0, voice_active}, 32'd0);
      chk("chord_req", {31'd0, note_done}, 32'd1);

      // fourth chord note steals the shortest-remaining voice (counts 4,2,3)
      give_note(6'd30, 6'd4, 3'b001, 3'b001, 1'b0);
      give_note(6'd31, 6'd2, 3'b001, 3'b010, 1'b0);
      give_note(6'd32, 6'd3, 3'b001, 3'b100, 1'b0);
      give_note(6'd33, 6'd5, 3'b000, 3'b010, 1'b1);
      chk("steal_gates", {29'd0, voice_active}, 32'b111);
      do_beat(); do_beat(); do_beat();
      chk("steal_after3", {29'd0, voice_active}, 32'b011);
      do_beat(); do_beat();
      chk("steal_drop", {29'd0, voice_active}, 32'd0);
      chk("steal_req", {31'd0, note_done}, 32'd1);

      // rest holds its beats without a voice; zero duration re-requests at once
      give_note(6'd0, 6'd2, 3'b000, '0, 1'b0);
      chk("rest_gate", {29'd0, voice_active}, 32'd0);
      do_beat();
      chk("rest_hold", {31'd0, note_done}, 32'd0);
      do_beat();
      chk("rest_req", {31'd0, note_done}, 32'd1);
      give_note(6'd5, 6'd0, 3'b000, '0, 1'b0);
      chk("dur0_req", {31'd0, note_done}, 32'd1);

      // pause during HOLD freezes counting
      give_note(6'd40, 6'd4, 3'b000, 3'b001, 1'b0);
      do_beat();
      play = 1'b0;
      repeat (5) do_beat();
      chk("pause_gate", {29'd0, voice_active}, 32'b001);
      chk("pause_no_req", {31'd0, note_done}, 32'd0);
      play = 1'b1;
      do_beat(); do_beat();
      chk("resume_hold", {31'd0, note_done}, 32'd0);
      do_beat();
      chk("resume_req", {31'd0, note_done}, 32'd1);
      chk("resume_drop", {29'd0, voice_active}, 32'd0);

      // song_done drains the sounding voice before finishing
      give_note(6'd50, 6'd3, 3'b001, 3'b001, 1'b0);
      wait_nd();
      step(1);
      song_done = 1'b1;
      step(1);
      song_done = 1'b0;
      chk("drain_wait", {31'd0, finished}, 32'd0);
      do_beat(); do_beat();
      chk("drain_wait2", {31'd0, finished}, 32'd0);
      do_beat();
      chk("drain_finished", {31'd0, finished}, 32'd1);

      // reset mid-HOLD with two voices sounding
      give_note(6'd60, 6'd5, 3'b001, 3'b001, 1'b0);
      give_note(6'd61, 6'd6, 3'b000, 3'b010, 1'b0);
      chk("pre_rst_gates", {29'd0, voice_active}, 32'b011);
      do_beat();
      reset = 1'b0;
      #2;
      chk("async_rst_active", {29'd0, voice_active}, 32'd0);
      chk("async_rst_nd",     {31'd0, note_done},    32'd0);
      step(2);
      reset = 1'b1;
      chk("release_idle", {31'd0, note_done}, 32'd0);
      step(1);
      chk("release_req", {31'd0, note_done}, 32'd1);

      chk("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
